i2c_master_multi: RTL and testbench

I2C_MASTER_MULTI -- requirements
Module: i2c_master_multi

---
 rtl/i2c_master_multi.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_master_multi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_multi.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_multi
//  Description : Single-master I2C controller. Supports 7/10-bit addressing,
//                multi-byte write and read, address-only probes and repeated
//                start for 10-bit reads. SCL can be held low on write underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_multi #(
  parameter int CLK_DIV = 25,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I2C_Start,
  input  logic             RW,
  input  logic             addr10,
  input  logic [9:0]       slave_addr,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       data_out,
  output logic             rx_valid,
  inout  wire              I2C_SDA,
  output logic             I2C_SCL,
  output logic             busy,
  output logic             done,
  output logic             nack_err
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] c_QLAST = QW'(CLK_DIV - 1);

  localparam logic [3:0] c_IDLE    = 4'd0;
  localparam logic [3:0] c_START   = 4'd1;
  localparam logic [3:0] c_HDR     = 4'd2;
  localparam logic [3:0] c_ADDR_LO = 4'd3;
  localparam logic [3:0] c_RSTART  = 4'd4;
  localparam logic [3:0] c_HDR_RD  = 4'd5;
  localparam logic [3:0] c_WRITE   = 4'd6;
  localparam logic [3:0] c_READ    = 4'd7;
  localparam logic [3:0] c_SACK    = 4'd8;
  localparam logic [3:0] c_MACK    = 4'd9;
  localparam logic [3:0] c_STOP    = 4'd10;

  logic [3:0]       r_state, w_next, r_prev;
  logic [QW-1:0]    r_qcnt;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [CNT_W-1:0] r_rem;
  logic [7:0]       r_sh, r_dout;
  logic [9:0]       r_addr;
  logic             r_rw, r_a10, r_sample, r_loaded;
  logic             r_busy, r_done, r_rxv, r_nack;
  logic             w_stall, w_load, w_run, w_qend, w_bend, w_byte_end;
  logic             w_scl, w_sda_oe, w_send;

  // A write byte is taken on the first clock of WRITE; without data the
  // quarter timer freezes with SCL low until tx_valid arrives.
  assign w_load     = (r_state == c_WRITE) && !r_loaded && tx_valid;
  assign w_stall    = (r_state == c_WRITE) && !r_loaded && !tx_valid;
  assign w_run      = (r_state != c_IDLE) && !w_stall;
  assign w_qend     = w_run && (r_qcnt == c_QLAST);
  assign w_bend     = w_qend && (r_q == 2'd3);
  assign w_byte_end = w_bend && (r_bit == 3'd7);
  assign w_send     = (r_state == c_HDR) || (r_state == c_ADDR_LO) ||
                      (r_state == c_HDR_RD) || (r_state == c_WRITE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; SACK routes on the phase that preceded it
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (I2C_Start) w_next = c_START;
      c_START: if (w_qend && r_q == 2'd1) w_next = c_HDR;
      c_HDR, c_ADDR_LO, c_HDR_RD, c_WRITE: if (w_byte_end) w_next = c_SACK;
      c_READ:  if (w_byte_end) w_next = c_MACK;
      c_RSTART: if (w_bend) w_next = c_HDR_RD;
      c_SACK: begin
        if (w_bend) begin
          if (r_sample) begin
            w_next = c_STOP;
          end else begin
            case (r_prev)
              c_HDR:     w_next = r_a10 ? c_ADDR_LO :
                                  (r_rem == '0) ? c_STOP : (r_rw ? c_READ : c_WRITE);
              c_ADDR_LO: w_next = (r_rem == '0) ? c_STOP : (r_rw ? c_RSTART : c_WRITE);
              c_HDR_RD:  w_next = c_READ;
              default:   w_next = (r_rem == '0) ? c_STOP : c_WRITE;
            endcase
          end
        end
      end
      c_MACK:  if (w_bend) w_next = (r_rem == '0) ? c_STOP : c_READ;
      c_STOP:  if (w_bend) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Bus outputs: SCL low in Q0-Q1, high in Q2-Q3; SDA only ever pulled low
  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    case (r_state)
      c_START: w_sda_oe = 1'b1;
      c_HDR, c_ADDR_LO, c_HDR_RD: begin
        w_scl    = r_q[1];
        w_sda_oe = ~r_sh[7];
      end
      c_WRITE: begin
        w_scl    = r_q[1];
        w_sda_oe = r_loaded & ~r_sh[7];
      end
      c_READ, c_SACK: w_scl = r_q[1];
      c_MACK: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_rem != '0);
      end
      c_RSTART: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_q == 2'd3);
      end
      c_STOP: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_q != 2'd3);
      end
      default: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  // Datapath: bit timing, shift register, byte counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qcnt   <= '0;
      r_q      <= '0;
      r_bit    <= '0;
      r_rem    <= '0;
      r_sh     <= '0;
      r_dout   <= '0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_a10    <= 1'b0;
      r_prev   <= c_IDLE;
      r_sample <= 1'b0;
      r_loaded <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rxv    <= 1'b0;
      r_nack   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rxv  <= 1'b0;

      if (w_next != r_state) begin
        r_qcnt <= '0;
        r_q    <= '0;
        r_bit  <= '0;
      end else if (w_run) begin
        if (w_qend) begin
          r_qcnt <= '0;
          r_q    <= r_q + 2'd1;
          if (r_q == 2'd3) r_bit <= r_bit + 3'd1;
        end else begin
          r_qcnt <= r_qcnt + QW'(1);
        end
      end

      if (w_next != r_state) begin
        case (w_next)
          c_HDR:     r_sh <= r_a10 ? {5'b11110, r_addr[9:8], 1'b0} : {r_addr[6:0], r_rw};
          c_ADDR_LO: r_sh <= r_addr[7:0];
          c_HDR_RD:  r_sh <= {5'b11110, r_addr[9:8], 1'b1};
          default:   r_sh <= r_sh;
        endcase
      end else if (w_load) begin
        r_sh <= tx_data;
      end else if (w_qend) begin
        if (r_state == c_READ && r_q == 2'd2) r_sh <= {r_sh[6:0], I2C_SDA};
        else if (w_send && r_q == 2'd3)       r_sh <= {r_sh[6:0], 1'b0};
      end

      if (w_qend && r_q == 2'd2) r_sample <= I2C_SDA;

      if (w_next == c_SACK && r_state != c_SACK) r_prev <= r_state;

      if (r_state != c_WRITE) r_loaded <= 1'b0;
      else if (w_load)        r_loaded <= 1'b1;

      if (w_byte_end && (r_state == c_WRITE || r_state == c_READ))
        r_rem <= r_rem - CNT_W'(1);

      if (w_byte_end && r_state == c_READ) begin
        r_dout <= r_sh;
        r_rxv  <= 1'b1;
      end

      if (r_state == c_SACK && w_bend && r_sample) r_nack <= 1'b1;

      if (r_state == c_STOP && w_bend) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end

      if (r_state == c_IDLE && I2C_Start) begin
        r_rw   <= RW;
        r_a10  <= addr10;
        r_addr <= slave_addr;
        r_rem  <= byte_count;
        r_busy <= 1'b1;
        r_nack <= 1'b0;
      end
    end
  end

  assign I2C_SDA  = w_sda_oe ? 1'b0 : 1'bz;
  assign I2C_SCL  = w_scl;
  assign tx_ready = w_load;
  assign data_out = r_dout;
  assign rx_valid = r_rxv;
  assign busy     = r_busy;
  assign done     = r_done;
  assign nack_err = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master_multi
//  Description : Directed bench for i2c_master_multi with a bus-level slave
//                model (ACK/data driving) and hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_multi;

  logic       clk = 1'b0;
  logic       rst, I2C_Start, RW, addr10, tx_valid;
  logic [9:0] slave_addr;
  logic [7:0] byte_count, tx_data;
  logic       tx_ready, rx_valid, I2C_SCL, busy, done, nack_err;
  logic [7:0] data_out;
  logic       slv_low = 1'b0;
  wire        sda;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_multi #(.CLK_DIV(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .I2C_Start(I2C_Start), .RW(RW), .addr10(addr10),
    .slave_addr(slave_addr), .byte_count(byte_count), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .data_out(data_out),
    .rx_valid(rx_valid), .I2C_SDA(sda), .I2C_SCL(I2C_SCL), .busy(busy),
    .done(done), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_pass = 0;
  int         n_busy = 0, n_txr = 0;
  logic [7:0] rxq[$];
  bit         abort = 1'b0;

  // Passive observation of pulses and busy duration
  always @(negedge clk) begin
    if (busy === 1'b1) n_busy++;
    if (tx_ready === 1'b1) n_txr++;
    if (rx_valid === 1'b1) rxq.push_back(data_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_scl(input logic lvl);
    int k = 0;
    while (!abort && I2C_SCL !== lvl && k < 400) begin @(negedge clk); k++; end
    if (!abort && I2C_SCL !== lvl) begin abort = 1'b1; chk("scl_wait", I2C_SCL, lvl); end
  endtask

  task automatic wait_sda(input logic lvl);
    int k = 0;
    while (!abort && sda !== lvl && k < 400) begin @(negedge clk); k++; end
    if (!abort && sda !== lvl) begin abort = 1'b1; chk("sda_wait", sda, lvl); end
  endtask

  task automatic wait_done(input string tag, input logic exp_nack);
    int k = 0;
    while (!abort && done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_nack"}, nack_err, exp_nack);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_scl_idle"}, I2C_SCL, 1'b1);
    chk({tag, "_sda_idle"}, sda, 1'b1);
    @(negedge clk);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      wait_scl(1'b0);
      wait_scl(1'b1);
      b[i] = sda;
    end
  endtask

  task automatic slave_ack();
    wait_scl(1'b0);
    slv_low = 1'b1;
    wait_scl(1'b1);
    wait_scl(1'b0);
    slv_low = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_scl(1'b0);
      slv_low = ~b[i];
      wait_scl(1'b1);
    end
  endtask

  task automatic master_ack(input string tag, input logic exp);
    wait_scl(1'b0);
    slv_low = 1'b0;
    wait_scl(1'b1);
    chk(tag, sda, exp);
  endtask

  task automatic start_txn(input logic rw, input logic a10, input logic [9:0] a,
                           input logic [7:0] cnt);
    @(negedge clk);
    RW = rw; addr10 = a10; slave_addr = a; byte_count = cnt;
    I2C_Start = 1'b1;
    @(negedge clk);
    I2C_Start = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_nack_clr", nack_err, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int         txr0, busy0, rx0;
    bit         all_low;

    rst = 1'b1; I2C_Start = 1'b0; RW = 1'b0; addr10 = 1'b0;
    slave_addr = '0; byte_count = '0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", I2C_SCL, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack_err, 1'b0);
    chk("rst_txr", tx_ready, 1'b0);
    chk("rst_rxv", rx_valid, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // 7-bit write 0x50, two bytes; a start pulse mid-transfer must be ignored
    txr0 = n_txr; busy0 = n_busy;
    tx_data = 8'hA5; tx_valid = 1'b1;
    start_txn(1'b0, 1'b0, 10'h050, 8'd2);
    recv_byte(b); chk("wr_hdr", b, 8'hA0);
    slave_ack();
    @(negedge clk);
    tx_data = 8'h3C;
    I2C_Start = 1'b1; slave_addr = 10'h011;
    @(negedge clk);
    I2C_Start = 1'b0;
    recv_byte(b); chk("wr_d0", b, 8'hA5);
    slave_ack();
    recv_byte(b); chk("wr_d1", b, 8'h3C);
    slave_ack();
    tx_valid = 1'b0;
    wait_done("wr", 1'b0);
    chk("wr_txready_cnt", n_txr - txr0, 2);
    chk("wr_busy_cycles", n_busy - busy0, 456);

    // 7-bit read 0x50, three bytes: ACK, ACK, NACK
    rx0 = rxq.size();
    start_txn(1'b1, 1'b0, 10'h050, 8'd3);
    recv_byte(b); chk("rd_hdr", b, 8'hA1);
    slave_ack();
    send_byte(8'h11); master_ack("rd_mack0", 1'b0);
    send_byte(8'h22); master_ack("rd_mack1", 1'b0);
    send_byte(8'h33); master_ack("rd_mack2", 1'b1);
    wait_done("rd", 1'b0);
    chk("rd_rx_cnt", rxq.size() - rx0, 3);
    chk("rd_rx0", rxq[rx0], 8'h11);
    chk("rd_rx1", rxq[rx0 + 1], 8'h22);
    chk("rd_rx2", rxq[rx0 + 2], 8'h33);
    chk("rd_dout", data_out, 8'h33);

    // 10-bit read 0x2C7, one byte, with repeated start
    rx0 = rxq.size();
    start_txn(1'b1, 1'b1, 10'h2C7, 8'd1);
    recv_byte(b); chk("a10_hdr", b, 8'hF4);
    slave_ack();
    recv_byte(b); chk("a10_lo", b, 8'hC7);
    slave_ack();
    wait_scl(1'b1);
    chk("a10_rs_sda_high", sda, 1'b1);
    wait_sda(1'b0);
    chk("a10_rs_scl_high", I2C_SCL, 1'b1);
    recv_byte(b); chk("a10_hdr_rd", b, 8'hF5);
    slave_ack();
    send_byte(8'h5A); master_ack("a10_mack", 1'b1);
    wait_done("a10", 1'b0);
    chk("a10_rx_cnt", rxq.size() - rx0, 1);
    chk("a10_rx0", rxq[rx0], 8'h5A);

    // Address NACK on a 7-bit write to 0x33
    txr0 = n_txr;
    tx_data = 8'h77; tx_valid = 1'b1;
    start_txn(1'b0, 1'b0, 10'h033, 8'd1);
    recv_byte(b); chk("nk_hdr", b, 8'h66);
    wait_done("nk", 1'b1);
    chk("nk_txready_cnt", n_txr - txr0, 0);
    tx_valid = 1'b0;

    // Write stretch: second byte withheld for 50 clocks
    txr0 = n_txr;
    tx_data = 8'h96; tx_valid = 1'b1;
    start_txn(1'b0, 1'b0, 10'h050, 8'd2);
    recv_byte(b); chk("st_hdr", b, 8'hA0);
    slave_ack();
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'hC3;
    recv_byte(b); chk("st_d0", b, 8'h96);
    slave_ack();
    all_low = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (I2C_SCL !== 1'b0) all_low = 1'b0;
    end
    chk("st_scl_held_low", all_low, 1'b1);
    chk("st_txready_before", n_txr - txr0, 1);
    tx_valid = 1'b1;
    recv_byte(b); chk("st_d1", b, 8'hC3);
    slave_ack();
    tx_valid = 1'b0;
    wait_done("st", 1'b0);
    chk("st_txready_cnt", n_txr - txr0, 2);

    // Reset during READ bit 3, then a normal address-only probe
    start_txn(1'b1, 1'b0, 10'h050, 8'd1);
    recv_byte(b); chk("rr_hdr", b, 8'hA1);
    slave_ack();
    for (int i = 7; i >= 4; i--) begin
      wait_scl(1'b0);
      slv_low = 1'b1;
      wait_scl(1'b1);
    end
    wait_scl(1'b0);
    rst = 1'b1; slv_low = 1'b0;
    @(negedge clk);
    chk("rr_scl", I2C_SCL, 1'b1);
    chk("rr_sda", sda, 1'b1);
    chk("rr_busy", busy, 1'b0);
    chk("rr_dout", data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    start_txn(1'b0, 1'b0, 10'h050, 8'd0);
    recv_byte(b); chk("rr_probe_hdr", b, 8'hA0);
    slave_ack();
    wait_done("rr_probe", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
